// File: rtl/matrix_loader.sv
// matrix_loader: writes a matrix-multiply job (header, A, B) from a word stream into data memory and releases the cores.
// Optional zeroing of the result region C after B is compiled in by defining MATRIX_LOADER_CLEAR_EN.
module matrix_loader #(
  parameter int DM_DEPTH = 10501,
  parameter int HDR_BASE = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        s_valid,
  input  logic [15:0] s_data,
  output logic        s_ready,
  output logic        dm_wr,
  output logic [15:0] dm_addr,
  output logic [15:0] dm_wdata,
  output logic        busy,
  output logic        cores_go,
  output logic        err,
  output logic [2:0]  fsm_state
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    HDR  = 3'd1,
    CHK  = 3'd2,
    MAT  = 3'd3,
    CLR  = 3'd4,
    DONE = 3'd5,
    ERR  = 3'd6
  } state_t;

  state_t      state;
  logic [15:0] addr;
  logic [1:0]  hdr_cnt;
  logic [15:0] dim_m, dim_k, dim_r, dim_n;
  logic [32:0] mat_left;
  logic [31:0] prod_a, prod_b, clr_words;
  logic [32:0] total;
  logic [34:0] image_end;
  logic        hdr_bad;
  logic        xfer;
`ifdef MATRIX_LOADER_CLEAR_EN
  logic [31:0] clr_left;
`endif

  // Handshake: a word moves on any rising edge where s_valid && s_ready; s_ready is a pure function of state.
  assign s_ready   = (state == HDR) || (state == MAT);
  assign xfer      = s_valid && s_ready;
  assign busy      = (state == HDR) || (state == CHK) || (state == MAT) || (state == CLR);
  assign fsm_state = state;

  assign prod_a = {16'd0, dim_m} * {16'd0, dim_k};
  assign prod_b = {16'd0, dim_r} * {16'd0, dim_n};
  assign total  = {1'b0, prod_a} + {1'b0, prod_b};
`ifdef MATRIX_LOADER_CLEAR_EN
  assign clr_words = {16'd0, dim_m} * {16'd0, dim_n};
`else
  assign clr_words = 32'd0;
`endif
  // Wide enough that the worst-case header cannot wrap the bound check.
  assign image_end = 35'(HDR_BASE + 4) + {2'b00, total} + {3'b000, clr_words};
  assign hdr_bad   = (dim_k != dim_r) || (dim_m == 16'd0) || (dim_k == 16'd0) ||
                     (dim_r == 16'd0) || (dim_n == 16'd0) || (image_end > 35'(DM_DEPTH));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      addr     <= 16'd0;
      hdr_cnt  <= 2'd0;
      dim_m    <= 16'd0;
      dim_k    <= 16'd0;
      dim_r    <= 16'd0;
      dim_n    <= 16'd0;
      mat_left <= 33'd0;
      dm_wr    <= 1'b0;
      dm_addr  <= 16'd0;
      dm_wdata <= 16'd0;
      cores_go <= 1'b0;
      err      <= 1'b0;
`ifdef MATRIX_LOADER_CLEAR_EN
      clr_left <= 32'd0;
`endif
    end else begin
      dm_wr <= 1'b0;
      case (state)
        IDLE, DONE, ERR: begin
          if (state == DONE) cores_go <= 1'b1;
          if (start) begin
            state    <= HDR;
            addr     <= 16'(HDR_BASE);
            hdr_cnt  <= 2'd0;
            cores_go <= 1'b0;
            err      <= 1'b0;
          end
        end
        HDR: begin
          if (xfer) begin
            case (hdr_cnt)
              2'd0:    dim_m <= s_data;
              2'd1:    dim_k <= s_data;
              2'd2:    dim_r <= s_data;
              default: dim_n <= s_data;
            endcase
            hdr_cnt <= hdr_cnt + 2'd1;
            if (hdr_cnt == 2'd3) state <= CHK;
          end
        end
        CHK: begin
          if (hdr_bad) begin
            state <= ERR;
            err   <= 1'b1;
          end else begin
            state    <= MAT;
            mat_left <= total;
          end
        end
        MAT: begin
          if (xfer) begin
            mat_left <= mat_left - 33'd1;
            if (mat_left == 33'd1) begin
`ifdef MATRIX_LOADER_CLEAR_EN
              state    <= CLR;
              clr_left <= clr_words;
`else
              state <= DONE;
`endif
            end
          end
        end
`ifdef MATRIX_LOADER_CLEAR_EN
        CLR: begin
          dm_wr    <= 1'b1;
          dm_addr  <= addr;
          dm_wdata <= 16'd0;
          addr     <= addr + 16'd1;
          clr_left <= clr_left - 32'd1;
          if (clr_left == 32'd1) state <= DONE;
        end
`endif
        default: state <= IDLE;
      endcase
      if (xfer) begin
        dm_wr    <= 1'b1;
        dm_addr  <= addr;
        dm_wdata <= s_data;
        addr     <= addr + 16'd1;
      end
    end
  end

endmodule
